// File: rtl/al422b_frame_reader.sv
// AL422B frame reader: rewinds the FIFO read pointer, clocks out one frame byte by byte and
// hands each byte to the RPi over a 4-phase valid/ack handshake. Macro ACK_TIMEOUT_EN adds an ack timeout.
module al422b_frame_reader #(
   parameter int unsigned FRAME_BYTES    = 153600,
   parameter int unsigned CNT_W          = 18,
   parameter int unsigned RCLK_HALF      = 2,
   parameter int unsigned RRST_PULSES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             frame_done,
   output logic             rclk,
   output logic             rrst,
   output logic             oe,
   input  logic [7:0]       d_in,
   output logic [7:0]       d_out,
   output logic             valid,
   input  logic             ack,
   output logic             busy,
   output logic             frame_err,
   output logic             dropped,
   output logic [3:0]       state_out,
   output logic [CNT_W-1:0] byte_cnt_out
);
   localparam int unsigned HALF_W = (RCLK_HALF > 1) ? $clog2(RCLK_HALF) : 1;
   localparam int unsigned IDX_W  = $clog2(2 * RRST_PULSES + 1);

   if (RCLK_HALF < 1 || RRST_PULSES < 1 || TIMEOUT_CYCLES < 1 ||
       (64'(1) << CNT_W) <= 64'(FRAME_BYTES)) begin : g_param_check
      $error("al422b_frame_reader: invalid parameter set");
   end

   typedef enum logic [3:0] {
      S_IDLE        = 4'd0,
      S_REWIND      = 4'd1,
      S_LEAD        = 4'd2,
      S_RCLK_HI     = 4'd3,
      S_RCLK_LO     = 4'd4,
      S_PRESENT     = 4'd5,
      S_WAIT_ACK_HI = 4'd6,
      S_WAIT_ACK_LO = 4'd7,
      S_DONE        = 4'd8
   } state_t;

   state_t            state_q, state_d;
   logic [HALF_W-1:0] half_q, half_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              rclk_q, rclk_d;
   logic              rrst_q, rrst_d;
   logic              oe_q, oe_d;
   logic [7:0]        d_out_q, d_out_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              dropped_q, dropped_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ack_meta_q, ack_meta_d;
   logic              ack_s_q, ack_s_d;
   logic              half_last;

`ifdef ACK_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            frame_err_q, frame_err_d;
`endif

   assign half_last = (half_q == HALF_W'(RCLK_HALF - 1));

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      half_d     = '0;
      idx_d      = idx_q;
      rclk_d     = rclk_q;
      rrst_d     = rrst_q;
      oe_d       = oe_q;
      d_out_d    = d_out_q;
      valid_d    = valid_q;
      busy_d     = busy_q;
      dropped_d  = 1'b0;
      cnt_d      = cnt_q;
      ack_meta_d = ack;
      ack_s_d    = ack_meta_q;
`ifdef ACK_TIMEOUT_EN
      to_cnt_d    = '0;
      frame_err_d = frame_err_q;
`endif

      if (frame_done && (state_q != S_IDLE)) begin
         dropped_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (frame_done) begin
               state_d = S_REWIND;
               busy_d  = 1'b1;
               oe_d    = 1'b0;
               cnt_d   = '0;
               rrst_d  = 1'b0;
               rclk_d  = 1'b0;
               idx_d   = '0;
            end
         end
         // Each rewind period is a low half then a high half, so rrst is set up before every rise
         S_REWIND: begin
            if (half_last) begin
               if (idx_q == IDX_W'(2 * RRST_PULSES - 1)) begin
                  state_d = S_LEAD;
                  idx_d   = '0;
                  rrst_d  = 1'b1;
                  rclk_d  = 1'b0;
               end else begin
                  idx_d  = idx_q + IDX_W'(1);
                  rclk_d = ~rclk_q;
               end
            end else begin
               half_d = half_q + HALF_W'(1);
            end
         end
         // Lead pulse with rrst released, bracketed by low halves: low, high, low
         S_LEAD: begin
            if (half_last) begin
               if (idx_q == IDX_W'(2)) begin
                  state_d = S_RCLK_HI;
                  idx_d   = '0;
                  rclk_d  = 1'b1;
               end else begin
                  idx_d  = idx_q + IDX_W'(1);
                  rclk_d = ~rclk_q;
               end
            end else begin
               half_d = half_q + HALF_W'(1);
            end
         end
         S_RCLK_HI: begin
            if (half_last) begin
               state_d = S_RCLK_LO;
               d_out_d = d_in;
               rclk_d  = 1'b0;
            end else begin
               half_d = half_q + HALF_W'(1);
            end
         end
         S_RCLK_LO: begin
            if (half_last) begin
               state_d = S_PRESENT;
            end else begin
               half_d = half_q + HALF_W'(1);
            end
         end
         S_PRESENT: begin
            state_d = S_WAIT_ACK_HI;
            valid_d = 1'b1;
         end
         S_WAIT_ACK_HI: begin
            if (ack_s_q) begin
               state_d = S_WAIT_ACK_LO;
               valid_d = 1'b0;
               if (cnt_q != CNT_W'(FRAME_BYTES)) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_WAIT_ACK_LO: begin
            if (!ack_s_q) begin
               if (cnt_q < CNT_W'(FRAME_BYTES)) begin
                  state_d = S_RCLK_HI;
                  rclk_d  = 1'b1;
               end else begin
                  state_d = S_DONE;
                  oe_d    = 1'b1;
                  busy_d  = 1'b0;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

`ifdef ACK_TIMEOUT_EN
      // Per-phase ack wait limit; handshake progress clears the counter
      if (((state_q == S_WAIT_ACK_HI) && !ack_s_q) ||
          ((state_q == S_WAIT_ACK_LO) && ack_s_q)) begin
         if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            valid_d     = 1'b0;
            oe_d        = 1'b1;
            busy_d      = 1'b0;
         end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         half_q      <= '0;
         idx_q       <= '0;
         rclk_q      <= 1'b0;
         rrst_q      <= 1'b1;
         oe_q        <= 1'b1;
         d_out_q     <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         dropped_q   <= 1'b0;
         cnt_q       <= '0;
         ack_meta_q  <= 1'b0;
         ack_s_q     <= 1'b0;
`ifdef ACK_TIMEOUT_EN
         to_cnt_q    <= '0;
         frame_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         half_q      <= half_d;
         idx_q       <= idx_d;
         rclk_q      <= rclk_d;
         rrst_q      <= rrst_d;
         oe_q        <= oe_d;
         d_out_q     <= d_out_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         dropped_q   <= dropped_d;
         cnt_q       <= cnt_d;
         ack_meta_q  <= ack_meta_d;
         ack_s_q     <= ack_s_d;
`ifdef ACK_TIMEOUT_EN
         to_cnt_q    <= to_cnt_d;
         frame_err_q <= frame_err_d;
`endif
      end
   end

   assign rclk         = rclk_q;
   assign rrst         = rrst_q;
   assign oe           = oe_q;
   assign d_out        = d_out_q;
   assign valid        = valid_q;
   assign busy         = busy_q;
   assign dropped      = dropped_q;
   assign state_out    = state_q;
   assign byte_cnt_out = cnt_q;
`ifdef ACK_TIMEOUT_EN
   assign frame_err    = frame_err_q;
`else
   assign frame_err    = 1'b0;
`endif

endmodule

// File: tb/tb_al422b_frame_reader.sv
// Bench for al422b_frame_reader: AL422B FIFO model, RPi handshake model and a byte scoreboard.
module tb_al422b_frame_reader;
   localparam int unsigned FB = 4;
   localparam int unsigned CW = 8;
   localparam int unsigned TO = 50;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          frame_done = 1'b0;
   logic          ack = 1'b0;
   logic [7:0]    d_in = 8'h00;
   logic          rclk, rrst, oe, valid, busy, frame_err, dropped;
   logic [7:0]    d_out;
   logic [3:0]    state_out;
   logic [CW-1:0] byte_cnt_out;

   always #5 clk = ~clk;

   al422b_frame_reader #(
      .FRAME_BYTES(FB), .CNT_W(CW), .RCLK_HALF(1), .RRST_PULSES(2), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .frame_done(frame_done), .rclk(rclk), .rrst(rrst),
      .oe(oe), .d_in(d_in), .d_out(d_out), .valid(valid), .ack(ack), .busy(busy),
      .frame_err(frame_err), .dropped(dropped), .state_out(state_out),
      .byte_cnt_out(byte_cnt_out)
   );

   int cmp_cnt = 0;
   int err_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // FIFO model: rises with rrst low rewind; first rise after release is a dummy, then one byte per rise
   logic [7:0] fifo_mem [FB];
   int unsigned rd_ptr = 0;
   bit          primed = 1'b0;
   int          rise_lo = 0;
   int          rise_hi = 0;

   always @(posedge rclk) begin
      if (!rrst) begin
         rd_ptr  = 0;
         primed  = 1'b0;
         rise_lo = rise_lo + 1;
      end else begin
         rise_hi = rise_hi + 1;
         if (primed) begin
            d_in   <= fifo_mem[rd_ptr % FB];
            rd_ptr = rd_ptr + 1;
         end else begin
            primed = 1'b1;
         end
      end
   end

   int drop_cyc = 0;
   int valid_pulses = 0;
   bit valid_prev = 1'b0;
   always @(negedge clk) begin
      if (dropped === 1'b1) drop_cyc = drop_cyc + 1;
      if (valid === 1'b1 && !valid_prev) valid_pulses = valid_pulses + 1;
      valid_prev = (valid === 1'b1);
   end

   // Scoreboard: frame stimulus pushes expected bytes, the RPi model pops on each presented byte
   logic [7:0] exp_q[$];
   bit mute = 1'b0;
   int ack_dly = 5;
   int ack_low_dly = 1;
   int popped = 0;

   task automatic serve_byte();
      logic [7:0] held;
      logic [7:0] exp;
      int r0;
      int lat;
      bit stable;
      held   = d_out;
      r0     = rise_lo + rise_hi;
      stable = 1'b1;
      check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
         exp = exp_q.pop_front();
         check("d_out", 32'(held), 32'(exp));
      end
      popped++;
      repeat (ack_dly) begin
         @(negedge clk);
         if (d_out !== held || valid !== 1'b1) stable = 1'b0;
      end
      check("hold_stable", 32'(stable), 32'd1);
      check("no_rclk_in_wait", 32'(rise_lo + rise_hi - r0), 32'd0);
      ack = 1'b1;
      lat = 0;
      while (valid === 1'b1 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check("ack_to_valid_lat", 32'(lat), 32'd3);
      repeat (ack_low_dly) @(negedge clk);
      ack = 1'b0;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (valid === 1'b1 && !ack && !mute) serve_byte();
      end
   end

   task automatic pulse_frame_done();
      frame_done = 1'b1;
      @(negedge clk);
      frame_done = 1'b0;
   endtask

   task automatic run_frame(input bit mid_drop);
      int lo0, hi0, d0, v0, p0, n;
      bit ok;
      @(negedge clk);
      lo0 = rise_lo; hi0 = rise_hi; d0 = drop_cyc; v0 = valid_pulses; p0 = popped;
      for (int i = 0; i < FB; i++) exp_q.push_back(fifo_mem[i]);
      pulse_frame_done();
      check("busy_start", 32'(busy), 32'd1);
      if (mid_drop) begin
         n = 0;
         while (popped < p0 + 2 && n < 5000) begin @(negedge clk); n++; end
         pulse_frame_done();
      end
      n = 0;
      while (busy === 1'b1 && n < 5000) begin @(negedge clk); n++; end
      ok = (busy === 1'b0);
      check("frame_end", 32'(ok), 32'd1);
      check("ack_low_at_end", 32'(ack), 32'd0);
      check("rewind_rises", 32'(rise_lo - lo0), 32'd2);
      check("lead_data_rises", 32'(rise_hi - hi0), 32'(FB + 1));
      check("valid_pulses", 32'(valid_pulses - v0), 32'(FB));
      check("bytes_served", 32'(popped - p0), 32'(FB));
      check("byte_cnt_out", 32'(byte_cnt_out), 32'(FB));
      check("dropped_cycles", 32'(drop_cyc - d0), mid_drop ? 32'd1 : 32'd0);
      check("oe_released", 32'(oe), 32'd1);
      @(negedge clk);
      check("state_idle", 32'(state_out), 32'd0);
      check("sb_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int n;
      #2 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rclk", 32'(rclk), 32'd0);
      check("rst_rrst", 32'(rrst), 32'd1);
      check("rst_oe", 32'(oe), 32'd1);
      check("rst_valid_busy", 32'({valid, busy, dropped, frame_err}), 32'd0);
      check("rst_d_out", 32'(d_out), 32'd0);
      check("rst_state", 32'(state_out), 32'd0);
      check("rst_cnt", 32'(byte_cnt_out), 32'd0);
      reset_n = 1'b1;

      for (int i = 0; i < FB; i++) fifo_mem[i] = 8'hA0 + 8'(i);
      ack_dly = 5; ack_low_dly = 1;
      run_frame(1'b0);

      for (int f = 0; f < 5; f++) begin
         for (int i = 0; i < FB; i++) fifo_mem[i] = 8'($urandom);
         ack_dly     = $urandom_range(0, 8);
         ack_low_dly = $urandom_range(0, 4);
         run_frame(f == 1);
      end

`ifdef ACK_TIMEOUT_EN
      ack_dly = 40;
`else
      ack_dly = 200;
`endif
      run_frame(1'b0);

      // Reset while a byte is waiting for ack
      mute = 1'b1;
      pulse_frame_done();
      n = 0;
      while (state_out !== 4'd6 && n < 200) begin @(negedge clk); n++; end
      check("reach_wait_ack_hi", 32'(state_out), 32'd6);
      check("valid_before_reset", 32'(valid), 32'd1);
      reset_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(valid), 32'd0);
      check("async_rst_oe", 32'(oe), 32'd1);
      check("async_rst_rrst", 32'(rrst), 32'd1);
      check("async_rst_state_busy", 32'({state_out, busy}), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      mute = 1'b0;
      for (int i = 0; i < FB; i++) fifo_mem[i] = 8'($urandom);
      ack_dly = 2;
      run_frame(1'b0);

`ifdef ACK_TIMEOUT_EN
      mute = 1'b1;
      pulse_frame_done();
      n = 0;
      while (valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      check("to_valid_seen", 32'(valid), 32'd1);
      n = 0;
      while (frame_err !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      check("to_latency_window", 32'(n >= 48 && n <= 52), 32'd1);
      check("to_valid_low", 32'(valid), 32'd0);
      check("to_oe_high", 32'(oe), 32'd1);
      check("to_state_idle", 32'(state_out), 32'd0);
      mute = 1'b0;
      ack_dly = 3;
      run_frame(1'b0);
      check("frame_err_sticky", 32'(frame_err), 32'd1);
`else
      check("frame_err_tied", 32'(frame_err), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, compared %0d", cmp_cnt);
      $fatal(1);
   end

endmodule
